// File: rtl/mult_acc.sv
// mult_acc: sequential shift-add multiply-accumulate, product = multiplicand * multiplier + addend,
// one multiplier bit per clock; valid/busy handshake shared with the sequential divider.
`default_nettype none

module mult_acc #(
  parameter int WIDTH = 32
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [WIDTH-1:0]   multiplicand_in,
  input  logic [WIDTH-1:0]   multiplier_in,
  input  logic [WIDTH-1:0]   addend_in,
  input  logic               data_valid_in,
  output logic [2*WIDTH-1:0] product_out,
  output logic               data_valid_out,
  output logic               overflow_out,
  output logic               busy_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {
    IDLE        = 1'b0,
    MULTIPLYING = 1'b1
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [2*WIDTH-1:0] mcand_sr;
  logic [WIDTH-1:0]   mplier_sr;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      count;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    acc_next   = acc;
    case (state)
      IDLE: begin
        if (data_valid_in) next_state = MULTIPLYING;
      end
      MULTIPLYING: begin
        // Max result is 2^2W - 2^W, so this sum never wraps.
        if (mplier_sr[0]) acc_next = acc + mcand_sr;
        if (count == '0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mcand_sr       <= '0;
      mplier_sr      <= '0;
      acc            <= '0;
      count          <= '0;
      product_out    <= '0;
      data_valid_out <= 1'b0;
      overflow_out   <= 1'b0;
      busy_out       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_valid_out <= 1'b0;
          if (data_valid_in) begin
            mcand_sr  <= {{WIDTH{1'b0}}, multiplicand_in};
            mplier_sr <= multiplier_in;
            acc       <= {{WIDTH{1'b0}}, addend_in};
            count     <= CW'(WIDTH - 1);
            busy_out  <= 1'b1;
          end
        end
        MULTIPLYING: begin
          acc       <= acc_next;
          mcand_sr  <= mcand_sr << 1;
          mplier_sr <= mplier_sr >> 1;
          if (count != '0) begin
            count <= count - CW'(1);
          end else begin
            product_out    <= acc_next;
            overflow_out   <= |acc_next[2*WIDTH-1:WIDTH];
            data_valid_out <= 1'b1;
            busy_out       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_acc.sv
// tb_mult_acc: table-driven and scoreboard-checked bench for mult_acc (WIDTH = 32).
`default_nettype none

module tb_mult_acc;

  localparam int W = 32;

  logic           clk_in;
  logic           rst_in;
  logic [W-1:0]   multiplicand_in;
  logic [W-1:0]   multiplier_in;
  logic [W-1:0]   addend_in;
  logic           data_valid_in;
  logic [2*W-1:0] product_out;
  logic           data_valid_out;
  logic           overflow_out;
  logic           busy_out;

  mult_acc #(.WIDTH(W)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .multiplicand_in (multiplicand_in),
    .multiplier_in   (multiplier_in),
    .addend_in       (addend_in),
    .data_valid_in   (data_valid_in),
    .product_out     (product_out),
    .data_valid_out  (data_valid_out),
    .overflow_out    (overflow_out),
    .busy_out        (busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    logic [2*W-1:0] p;
    logic           o;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] p;
    logic           o;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every valid pulse must match the oldest outstanding request.
  always @(negedge clk_in) begin
    check("busy_valid_exclusive", {63'd0, busy_out & data_valid_out}, 64'd0);
    if (data_valid_out) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data_valid_out=1 expected 0 (product 0x%0h)", product_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("product", product_out, e.p);
        check("overflow", {63'd0, overflow_out}, {63'd0, e.o});
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] a, b, c);
    exp_t e;
    e.p = {32'd0, a} * {32'd0, b} + {32'd0, c};
    e.o = |e.p[2*W-1:W];
    return e;
  endfunction

  task automatic start_req(input logic [W-1:0] a, b, c, input logic [2*W-1:0] p, input logic o);
    exp_t e;
    @(negedge clk_in);
    multiplicand_in = a;
    multiplier_in   = b;
    addend_in       = c;
    data_valid_in   = 1'b1;
    @(posedge clk_in);
    #1;
    e.p = p;
    e.o = o;
    q.push_back(e);
    check("busy_at_accept", {63'd0, busy_out}, 64'd1);
    data_valid_in   = 1'b0;
    multiplicand_in = $urandom;
    multiplier_in   = $urandom;
    addend_in       = $urandom;
  endtask

  task automatic wait_dv(input int max_edges, output int n, output logic busy_bad);
    busy_bad = 1'b0;
    n = 0;
    for (int i = 1; i <= max_edges + 1; i++) begin
      @(posedge clk_in);
      #1;
      n = i;
      if (data_valid_out) break;
      if (!busy_out) busy_bad = 1'b1;
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, b, c, input logic [2*W-1:0] p, input logic o);
    int   n;
    logic bb;
    start_req(a, b, c, p, o);
    wait_dv(40, n, bb);
    check("latency", 64'(n), 64'd32);
    check("busy_held_during_op", {63'd0, bb}, 64'd0);
    check("busy_low_at_valid", {63'd0, busy_out}, 64'd0);
    @(posedge clk_in);
    #1;
    check("valid_one_cycle", {63'd0, data_valid_out}, 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int   n;
    logic bb;
    exp_t e;

    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic bb;
    exp_t e;

    vecs[0] = '{a: 32'd7,          b: 32'd6,          c: 32'd5,          p: 64'd47,                  o: 1'b0};
    vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   c: 32'hFFFFFFFF,   p: 64'hFFFFFFFF_00000000,   o: 1'b1};
    vecs[2] = '{a: 32'h00010000,   b: 32'h00010000,   c: 32'd0,          p: 64'h00000001_00000000,   o: 1'b1};
    vecs[3] = '{a: 32'd142,        b: 32'd7,          c: 32'd6,          p: 64'd1000,                o: 1'b0};
    vecs[4] = '{a: 32'd0,          b: 32'hDEADBEEF,   c: 32'h1234,       p: 64'h1234,                o: 1'b0};
    vecs[5] = '{a: 32'hFFFFFFFF,   b: 32'd2,          c: 32'd1,          p: 64'h00000001_FFFFFFFF,   o: 1'b1};

    rst_in          = 1'b1;
    data_valid_in   = 1'b0;
    multiplicand_in = '0;
    multiplier_in   = '0;
    addend_in       = '0;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_product", product_out, 64'd0);
    check("reset_valid", {63'd0, data_valid_out}, 64'd0);
    check("reset_overflow", {63'd0, overflow_out}, 64'd0);
    check("reset_busy", {63'd0, busy_out}, 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;

    for (int i = 0; i < 6; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].p, vecs[i].o);

    // Request arriving mid-operation must be dropped, not queued.
    start_req(32'd3, 32'd4, 32'd0, 64'd12, 1'b0);
    repeat (9) @(posedge clk_in);
    #1;
    multiplicand_in = 32'd9;
    multiplier_in   = 32'd9;
    addend_in       = 32'd0;
    data_valid_in   = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    data_valid_in = 1'b0;
    wait_dv(40, n, bb);
    check("ignore_latency", 64'(n), 64'd18);
    repeat (40) @(posedge clk_in);
    #1;
    check("ignore_hold_product", product_out, 64'd12);
    check("ignore_idle_busy", {63'd0, busy_out}, 64'd0);

    // Asynchronous reset between edges aborts an operation in flight.
    start_req(32'd5, 32'd5, 32'd5, 64'd30, 1'b0);
    repeat (15) @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    check("async_rst_product", product_out, 64'd0);
    check("async_rst_valid", {63'd0, data_valid_out}, 64'd0);
    check("async_rst_overflow", {63'd0, overflow_out}, 64'd0);
    check("async_rst_busy", {63'd0, busy_out}, 64'd0);
    q.delete();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (40) @(posedge clk_in);
    #1;
    check("post_rst_busy", {63'd0, busy_out}, 64'd0);
    do_op(32'd2, 32'd3, 32'd1, 64'd7, 1'b0);

    // Back-to-back: held request with operands changing every cycle.
    for (int i = 0; i < 99; i++) begin
      @(negedge clk_in);
      multiplicand_in = $urandom;
      multiplier_in   = $urandom;
      addend_in       = $urandom;
      data_valid_in   = 1'b1;
      @(posedge clk_in);
      if (i % 33 == 0) begin
        e = model(multiplicand_in, multiplier_in, addend_in);
        q.push_back(e);
      end
    end
    @(negedge clk_in);
    data_valid_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("b2b_all_results", 64'(q.size()), 64'd0);

    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a, b, c;
      a = $urandom;
      b = $urandom;
      c = $urandom;
      if (i % 10 == 0) a = 32'hFFFFFFFF;
      if (i % 17 == 0) b = 32'd0;
      e = model(a, b, c);
      do_op(a, b, c, e.p, e.o);
    end

    repeat (2) @(posedge clk_in);
    #1;
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_acc.md
# mult_acc

Sequential shift-add multiply-accumulate unit computing product = multiplicand × multiplier + addend, one multiplier bit per clock. It is the inverse of the team's sequential divider: feeding it the divider's quotient, divisor and remainder reconstructs the original dividend. It shares the divider's valid/busy handshake so both can sit side by side in the wk1 datapath and in self-checking benches.

## Interface

- WIDTH, 32: operand width in bits; product is 2·WIDTH bits.

Clock and reset: one clock (clk_in); reset (rst_in) is asynchronous and active-high.

- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- multiplicand_in  input  WIDTH  unsigned multiplicand, sampled on accept.
- multiplier_in  input  WIDTH  unsigned multiplier, sampled on accept.
- addend_in  input  WIDTH  unsigned addend, zero-extended, sampled on accept.
- data_valid_in  input  1  request; accepted only when idle.
- product_out  output  2·WIDTH  result; holds last value until next completion.
- data_valid_out  output  1  one-cycle pulse, product_out valid.
- overflow_out  output  1  product_out[2·WIDTH-1:WIDTH] nonzero; updated with data_valid_out.
- busy_out  output  1  high while an operation is in flight.

## Operation

- States: IDLE, MULTIPLYING.
- IDLE: if data_valid_in, latch multiplicand into a 2·WIDTH shift register (zero-extended), multiplier into a WIDTH shift register, accumulator <= zero-extended addend, count <= WIDTH-1, busy_out <= 1, go to MULTIPLYING. data_valid_out <= 0 on every IDLE edge.
- MULTIPLYING, each edge: if multiplier LSB = 1, acc <= acc + multiplicand register; multiplicand register shifts left 1, multiplier shifts right 1.
  - count ≠ 0: count <= count-1.
  - count = 0: product_out <= final acc (including this iteration's add), overflow_out <= upper half of that value ≠ 0, data_valid_out <= 1, busy_out <= 0, go to IDLE.
- Arithmetic: all unsigned. Max result (2^W-1)^2 + (2^W-1) = 2^2W - 2^W, fits in 2·WIDTH bits; accumulator never wraps.
- data_valid_in while MULTIPLYING is ignored (not queued); inputs may change freely after accept.
- No early termination: latency is independent of operand values, including zero operands.
- Reset (any time, including mid-operation): state IDLE, product_out 0, data_valid_out 0, overflow_out 0, busy_out 0, internal registers 0. An aborted operation never produces data_valid_out.

## Timing

- Accept at edge k (IDLE, data_valid_in = 1): busy_out high from k.
- Iterations on edges k+1 … k+WIDTH; at edge k+WIDTH: data_valid_out = 1, busy_out = 0, product_out/overflow_out valid.
- Latency: WIDTH cycles accept-to-valid; data_valid_out high exactly one cycle.
- A new request may be accepted at edge k+WIDTH+1 (the edge that clears data_valid_out): throughput one result per WIDTH+1 cycles.
- busy_out and data_valid_out are never both high.
- Reset deasserted: first possible accept on the first rising edge with rst_in low.

## Test plan

- WIDTH=32, multiplicand 7, multiplier 6, addend 5 -> after 32 cycles data_valid_out pulses one cycle, product_out = 47, overflow_out 0, busy_out high for exactly cycles k..k+31.
- 0xFFFFFFFF × 0xFFFFFFFF + 0xFFFFFFFF -> product_out = 0xFFFFFFFF_00000000, overflow_out 1; 0x10000 × 0x10000 + 0 -> 0x1_00000000, overflow_out 1.
- Divider round trip: 142 × 7 + 6 -> 1000; 0 × 0xDEADBEEF + 0x1234 -> 0x1234 with full 32-cycle latency; random 1000 vectors against a reference model.
- Pulse data_valid_in with 3 × 4 + 0, then reassert data_valid_in with 9 × 9 + 0 at cycle k+10 -> ignored; single result 12; product_out then holds 12.
- Assert rst_in asynchronously (between edges) at cycle k+15 -> all outputs 0 immediately, no data_valid_out afterwards; next request 2 × 3 + 1 -> 7 after 32 cycles.
- Back-to-back: hold data_valid_in high with changing operands -> accepts every 33 cycles, each result matches operands sampled at its accept edge.
